// File: rtl/alu_execute_if.sv
// Handshake and data bundle between the shifter/issue side and alu_execute.
// slave is the execute stage; master is whatever feeds it and drains it.
interface alu_execute_if #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 3
);
  logic             InValid;
  logic             InReady;
  logic [2:0]       AluOp;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] ShiftedB;
  logic [TAGW-1:0]  DestIn;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic [TAGW-1:0]  DestOut;
  logic [3:0]       Flags;
  logic             Busy;

  modport master (
    output InValid, AluOp, OperandA, ShiftedB, DestIn, OutReady,
    input  InReady, OutValid, Result, DestOut, Flags, Busy
  );

  modport slave (
    input  InValid, AluOp, OperandA, ShiftedB, DestIn, OutReady,
    output InReady, OutValid, Result, DestOut, Flags, Busy
  );
endinterface

// File: rtl/alu_execute.sv
// 16-bit execute stage: single-cycle ALU ops plus an optional 16-step signed
// multiplier compiled in with ALU_EXECUTE_MUL_EN; state visible on state_dbg.
module alu_execute #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  alu_execute_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;
  localparam int         MSB      = WIDTH - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

  state_t           state, state_next;
  logic             xfer_in, xfer_out, load_alu, clear_valid;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  // Valid/ready: a word moves on any edge where valid and ready are both high;
  // a producer holding valid keeps its data stable until that edge.
  assign xfer_in       = bus.InValid && bus.InReady;
  assign xfer_out      = bus.OutValid && bus.OutReady;
  assign bus.InReady   = (state == ST_IDLE) && (!bus.OutValid || bus.OutReady);
  assign state_dbg     = state;

  assign sum  = {1'b0, bus.OperandA} + {1'b0, bus.ShiftedB};
  assign diff = {1'b0, bus.OperandA} - {1'b0, bus.ShiftedB};

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.AluOp)
      OP_ADD: begin
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.OperandA[MSB] == bus.ShiftedB[MSB]) && (sum[MSB] != bus.OperandA[MSB]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow, i.e. A < B unsigned
        alu_r = diff[MSB:0];
        alu_c = diff[WIDTH];
        alu_v = (bus.OperandA[MSB] != bus.ShiftedB[MSB]) && (diff[MSB] != bus.OperandA[MSB]);
      end
      OP_AND:   alu_r = bus.OperandA & bus.ShiftedB;
      OP_OR:    alu_r = bus.OperandA | bus.ShiftedB;
      OP_XOR:   alu_r = bus.OperandA ^ bus.ShiftedB;
      OP_PASSB: alu_r = bus.ShiftedB;
      OP_SLT:   alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.OperandA) < $signed(bus.ShiftedB))};
      OP_MUL:   alu_r = '0;
      default:  alu_r = '0;
    endcase
  end

`ifdef ALU_EXECUTE_MUL_EN
  logic               start_mul, mul_step, mul_done, mul_ovf;
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier, prod_lo;
  logic [4:0]         cnt;
  logic [TAGW-1:0]    mul_tag;

  // Sign-corrected shift-add: the multiplier MSB carries weight -2^15.
  always_comb begin
    acc_step = acc;
    if (mplier[0])
      acc_step = (cnt == 5'd15) ? acc - mcand : acc + mcand;
  end

  assign prod_lo  = acc_step[MSB:0];
  assign mul_ovf  = acc_step[2*WIDTH-1:WIDTH] != {WIDTH{prod_lo[MSB]}};
  assign bus.Busy = (state == ST_MUL);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      mul_tag <= '0;
    end else if (start_mul) begin
      mcand   <= {{WIDTH{bus.OperandA[MSB]}}, bus.OperandA};
      mplier  <= bus.ShiftedB;
      acc     <= '0;
      cnt     <= '0;
      mul_tag <= bus.DestIn;
    end else if (mul_step) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= acc_step;
      cnt     <= cnt + 5'd1;
    end
  end
`else
  assign bus.Busy = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_alu    = 1'b0;
    clear_valid = 1'b0;
`ifdef ALU_EXECUTE_MUL_EN
    start_mul   = 1'b0;
    mul_step    = 1'b0;
    mul_done    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (xfer_in) begin
`ifdef ALU_EXECUTE_MUL_EN
          if (bus.AluOp == OP_MUL) begin
            start_mul  = 1'b1;
            state_next = ST_MUL;
          end else begin
            load_alu = 1'b1;
          end
`else
          load_alu = 1'b1;
`endif
        end else if (xfer_out) begin
          clear_valid = 1'b1;
        end
      end
`ifdef ALU_EXECUTE_MUL_EN
      ST_MUL: begin
        mul_step = 1'b1;
        if (cnt == 5'd15) begin
          mul_done   = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (xfer_out) begin
          clear_valid = 1'b1;
          state_next  = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.OutValid <= 1'b0;
      bus.Result   <= '0;
      bus.DestOut  <= '0;
      bus.Flags    <= '0;
    end else begin
      if (load_alu) begin
        bus.Result   <= alu_r;
        bus.Flags    <= {alu_r[MSB], (alu_r == '0), alu_c, alu_v};
        bus.DestOut  <= bus.DestIn;
        bus.OutValid <= 1'b1;
      end else if (clear_valid) begin
        bus.OutValid <= 1'b0;
      end
`ifdef ALU_EXECUTE_MUL_EN
      if (start_mul) bus.OutValid <= 1'b0;
      if (mul_done) begin
        bus.Result   <= prod_lo;
        bus.Flags    <= {prod_lo[MSB], (prod_lo == '0), 1'b0, mul_ovf};
        bus.DestOut  <= mul_tag;
        bus.OutValid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Bench for alu_execute: directed literal checks plus randomized traffic scored
// against an arithmetic model; honours ALU_EXECUTE_MUL_EN like the design.
module tb_alu_execute;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] state_dbg;

  alu_execute_if #(.WIDTH(16), .TAGW(3)) bus ();

  alu_execute #(.WIDTH(16), .TAGW(3)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit in_reset = 1'b1;
  bit rand_rdy = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry = {Result, Flags, DestOut}
  logic [22:0] exp_q[$];
  int          due_q[$];
  int          acc_q[$];
  bit          mul_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit op_is_mul(input logic [2:0] op);
`ifdef ALU_EXECUTE_MUL_EN
    return op == 3'b111;
`else
    return 1'b0;
`endif
  endfunction

  // {result[15:0], N, Z, C, V} from plain integer arithmetic
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [31:0] rv;
    logic [15:0] res;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      3'd1: begin r = ua - ub; c = (ua < ub);   s = sa - sb; v = (s > 32767) || (s < -32768); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ub;
      3'd6: r = (sa < sb) ? 1 : 0;
      default: begin
`ifdef ALU_EXECUTE_MUL_EN
        r = sa * sb;
        v = (r > 32767) || (r < -32768);
`else
        r = 0;
`endif
      end
    endcase
    rv = r;
    res = rv[15:0];
    return {res, res[15], (res == 16'h0000), c, v};
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    bus.InValid = 1'b0;
  endtask

  // Presents one op and returns at the negedge after it was accepted.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] tag);
    int  waited = 0;
    bit  done = 1'b0;
    bus.InValid  = 1'b1;
    bus.AluOp    = op;
    bus.OperandA = a;
    bus.ShiftedB = b;
    bus.DestIn   = tag;
    while (!done) begin
      #1;
      if (bus.InReady) begin
        exp_q.push_back({model(op, a, b), tag});
        due_q.push_back(cyc + (op_is_mul(op) ? 17 : 1));
        acc_q.push_back(cyc);
        mul_q.push_back(op_is_mul(op));
        done = 1'b1;
      end
      @(negedge Clk);
      if (!done) begin
        waited++;
        if (waited > 40) begin
          vectors++;
          fails++;
          $display("FAIL accept_timeout: InReady never rose for op %0d", op);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); due_q.delete(); acc_q.delete(); mul_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    in_reset = 1'b1;
    clear_model();
    idle();
    Reset = 1'b1;
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
    in_reset = 1'b0;
  endtask

  // ---------------- compare process ----------------
  initial begin
    bit exp_v, pend_mul, exp_busy;
    forever begin
      @(negedge Clk);
      #4;
      if (!in_reset) begin
        exp_v = (exp_q.size() > 0) && (due_q[0] <= cyc);
        pend_mul = 1'b0;
        exp_busy = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (mul_q[i] && acc_q[i] < cyc) begin
            pend_mul = 1'b1;
            if (cyc < due_q[i]) exp_busy = 1'b1;
          end
        end
        check("out_valid", bus.OutValid, exp_v);
        check("in_ready", bus.InReady, !pend_mul && (!exp_v || bus.OutReady));
        check("busy", bus.Busy, exp_busy);
        if (bus.OutValid && exp_v) begin
          check("result_flags_tag", {bus.Result, bus.Flags, bus.DestOut}, exp_q[0]);
          if (bus.OutReady) begin
            void'(exp_q.pop_front()); void'(due_q.pop_front());
            void'(acc_q.pop_front()); void'(mul_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (rand_rdy) bus.OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] pick_operand();
    logic [15:0] edges[5];
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    int budget;
    bus.InValid = 1'b0; bus.AluOp = '0; bus.OperandA = '0; bus.ShiftedB = '0;
    bus.DestIn = '0; bus.OutReady = 1'b1;

    // the model itself, against hand-computed values
    check("model_add_ovf", model(3'd0, 16'h7FFF, 16'h0001), {16'h8000, 4'b1001});
    check("model_sub_borrow", model(3'd1, 16'h0003, 16'h0005), {16'hFFFE, 4'b1010});
    check("model_slt", model(3'd6, 16'h0003, 16'h0005), {16'h0001, 4'b0000});
`ifdef ALU_EXECUTE_MUL_EN
    check("model_mul_neg", model(3'd7, 16'hFFFD, 16'h0007), {16'hFFEB, 4'b1000});
    check("model_mul_ovf", model(3'd7, 16'h0100, 16'h0100), {16'h0000, 4'b0101});
`else
    check("model_mul_off", model(3'd7, 16'h1234, 16'h5678), {16'h0000, 4'b0100});
`endif

    @(negedge Clk);
    do_reset(3);
    check("rst_out_valid", bus.OutValid, 1'b0);
    check("rst_result", bus.Result, 16'h0000);
    check("rst_flags", bus.Flags, 4'h0);
    check("rst_dest", bus.DestOut, 3'd0);
    check("rst_busy", bus.Busy, 1'b0);
    #1 check("rst_in_ready", bus.InReady, 1'b1);
    @(negedge Clk);

    // ADD overflow, then the result drains and holds its value
    send(3'd0, 16'h7FFF, 16'h0001, 3'd3);
    idle();
    check("add_result", bus.Result, 16'h8000);
    check("add_flags", bus.Flags, 4'b1001);
    check("add_dest", bus.DestOut, 3'd3);
    @(negedge Clk);
    check("drain_valid_low", bus.OutValid, 1'b0);
    check("drain_result_held", bus.Result, 16'h8000);

    // SUB then SLT back to back
    send(3'd1, 16'h0003, 16'h0005, 3'd1);
    check("sub_result", bus.Result, 16'hFFFE);
    check("sub_flags", bus.Flags, 4'b1010);
    send(3'd6, 16'h0003, 16'h0005, 3'd2);
    idle();
    check("b2b_valid", bus.OutValid, 1'b1);
    check("slt_result", bus.Result, 16'h0001);
    check("slt_dest", bus.DestOut, 3'd2);
    @(negedge Clk);

    // backpressure
    bus.OutReady = 1'b0;
    send(3'd0, 16'h1234, 16'h0001, 3'd5);
    idle();
    repeat (3) begin
      #1;
      check("bp_in_ready", bus.InReady, 1'b0);
      check("bp_valid", bus.OutValid, 1'b1);
      check("bp_result", bus.Result, 16'h1235);
      @(negedge Clk);
    end
    bus.OutReady = 1'b1;
    #1 check("bp_release_ready", bus.InReady, 1'b1);
    @(negedge Clk);
    check("bp_drained", bus.OutValid, 1'b0);

`ifdef ALU_EXECUTE_MUL_EN
    send(3'd7, 16'hFFFD, 16'h0007, 3'd6);
    idle();
    for (int i = 0; i < 16; i++) begin
      check("mul_busy", bus.Busy, 1'b1);
      check("mul_not_valid", bus.OutValid, 1'b0);
      @(negedge Clk);
    end
    check("mul_valid", bus.OutValid, 1'b1);
    check("mul_result", bus.Result, 16'hFFEB);
    check("mul_flags", bus.Flags, 4'b1000);
    check("mul_busy_done", bus.Busy, 1'b0);
    @(negedge Clk);
    send(3'd7, 16'h0100, 16'h0100, 3'd4);
    idle();
    budget = 0;
    while (!bus.OutValid && budget < 30) begin @(negedge Clk); budget++; end
    check("mul2_result", bus.Result, 16'h0000);
    check("mul2_flags", bus.Flags, 4'b0101);
    @(negedge Clk);

    // reset on the 8th multiply cycle
    send(3'd0, 16'h0001, 16'h0001, 3'd0);
    send(3'd7, 16'h0123, 16'h0045, 3'd7);
    idle();
    repeat (7) @(negedge Clk);
    check("abort_busy_before", bus.Busy, 1'b1);
    in_reset = 1'b1;
    clear_model();
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_valid", bus.OutValid, 1'b0);
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_result", bus.Result, 16'h0000);
    Reset = 1'b0;
    in_reset = 1'b0;
    #1 check("abort_in_ready", bus.InReady, 1'b1);
    @(negedge Clk);
`else
    send(3'd7, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'd6);
    idle();
    check("mul_off_result", bus.Result, 16'h0000);
    check("mul_off_flags", bus.Flags, 4'b0100);
    @(negedge Clk);
`endif

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(negedge Clk);
      end
      send(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 3'($urandom_range(0, 7)));
    end
    idle();
    rand_rdy = 1'b0;
    bus.OutReady = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin @(negedge Clk); budget++; end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/alu_execute.md
# alu_execute

Execute stage directly downstream of the barrel shifter in the 16-bit datapath. It combines operand A with the shifted B operand (`ShiftedB`), registers a 16-bit result, a destination tag and NZCV flags, and hands them to writeback over a valid/ready handshake. Single-cycle ops sustain one result per clock. An optional multi-cycle signed multiplier adds a small state machine.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; only 16 is supported.
- `TAGW`, 3, width of the destination-register tag.

Ports:
- `Clk`  in  1  — clock; all state changes on the rising edge.
- `Reset`  in  1  — synchronous, active-high.
- `InValid`  in  1  — operands and op are valid this cycle.
- `InReady`  out  1  — stage can accept this cycle.
- `AluOp`  in  3  — 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 SLT, 111 MUL.
- `OperandA`  in  16 (signed)  — A operand.
- `ShiftedB`  in  16 (signed)  — B operand, taken from the barrel shifter output.
- `DestIn`  in  `TAGW`  — destination tag; passed through unchanged.
- `OutValid`  out  1  — `Result`, `DestOut` and `Flags` are valid.
- `OutReady`  in  1  — downstream accepts this cycle.
- `Result`  out  16  — registered result.
- `DestOut`  out  `TAGW`  — registered tag.
- `Flags`  out  4  — {N, Z, C, V}, registered.
- `Busy`  out  1  — high while in state MUL.

## Operation
- Transfer in: occurs when `InValid && InReady`. Transfer out: occurs when `OutValid && OutReady`.
- States:
  - IDLE: output register empty or holding a single-cycle result.
  - MUL: multiply iterating.
  - HOLD: multiply result waiting for the consumer.
- `InReady` = (state == IDLE) && (!OutValid || OutReady).
- IDLE, accepted non-MUL op: compute and register `Result`, `Flags`, `DestOut` at that edge; `OutValid` goes to 1.
- IDLE, transfer out with no new accept: `OutValid` goes to 0. `Result`, `Flags` and `DestOut` hold their last values.
- Accept while the previous result is leaving (back-to-back): the new result replaces the old one in the same edge; `OutValid` stays 1.
- Arithmetic (all 16-bit):
  - ADD: C = carry out of bit 15 (unsigned); V = signed overflow.
  - SUB: A − B. C = borrow, i.e. 1 iff A < B unsigned; V = signed overflow.
  - AND, OR, XOR, PASSB: C = 0, V = 0.
  - SLT: `Result` = 1 if A < B signed, else 0; C = 0, V = 0.
- N = `Result`[15]. Z = (`Result` == 0). These two hold for every op.
- MUL (only with the macro, see Configuration):
  - Accept: load operands, clear a 5-bit counter and a 32-bit accumulator, latch the tag, go to MUL. `OutValid` goes to 0 at this edge.
  - Each cycle in MUL performs one radix-2 signed shift-add step (Booth or sign-corrected) and increments the counter.
  - After the 16th step: `Result` = product[15:0], V = 1 iff the 32-bit product ≠ sign-extension of product[15:0], C = 0. `OutValid` goes to 1 and the state goes to HOLD.
  - HOLD → IDLE on transfer out. HOLD never accepts (`InReady` = 0).
- `AluOp` 111 without the macro: behaves as a single-cycle op with `Result` = 0, Flags = {0, 1, 0, 0}.
- Reset:
  - `OutValid` = 0, `Result` = 0, `DestOut` = 0, `Flags` = 0, `Busy` = 0, state IDLE, counter = 0.
  - `InReady` reads 1 in the cycle after reset deasserts.
  - Reset during MUL or HOLD aborts the multiply; the result is discarded.

## Timing
- Single-cycle ops: latency 1. Accepted at edge k, visible after edge k.
- Throughput for single-cycle ops: 1 op/cycle while `OutReady` = 1.
- MUL: accepted at edge k, `OutValid` rises after edge k+16. `InReady` = 0 from after edge k until the cycle the result transfers out.
- `OutReady` low: `Result`, `Flags`, `DestOut` and `OutValid` are stable until the transfer out.
- `InReady` depends combinationally on `OutReady`. No other combinational input-to-output path exists.

## Configuration
- `ALU_EXECUTE_MUL_EN`:
  - Defined: MUL state, counter, accumulator and `Busy` logic are compiled in.
  - Undefined: no multiplier logic; `Busy` is tied to 0 and `AluOp` 111 behaves as stated under Operation.

## Test plan
- ADD 0x7FFF + 0x0001, `OutReady` = 1 → after 1 cycle `Result` = 0x8000, Flags N = 1, Z = 0, C = 0, V = 1.
- SUB 0x0003 − 0x0005, then SLT with the same operands on the next cycle → `Result` = 0xFFFE, C = 1, V = 0; next `Result` = 0x0001. Also confirms back-to-back `OutValid` stays 1.
- Backpressure: issue ADD with `OutReady` = 0 for 3 cycles → `InReady` = 0 and the output is held stable; raise `OutReady` → transfer occurs and `InReady` returns to 1 in that cycle.
- MUL (macro defined): 0xFFFD × 0x0007 → `Busy` for 16 cycles, `OutValid` after edge k+16, `Result` = 0xFFEB, V = 0. Then 0x0100 × 0x0100 → `Result` = 0x0000, Z = 1, V = 1.
- Reset asserted on the 8th MUL cycle → next cycle `OutValid` = 0, `Busy` = 0, `Result` = 0, `InReady` = 1 once reset drops.
- Macro undefined: `AluOp` 111 with any operands → 1-cycle latency, `Result` = 0, Flags = {0, 1, 0, 0}.
